// File: rtl/store_word_buffer_pkg.sv
// Shared types for the store word buffer: drain FSM states, default widths, FIFO entry.
package store_buf_pkg;

  localparam int unsigned StoreAddrW = 19;
  localparam int unsigned StoreDataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRelease
  } drain_state_e;

  typedef struct packed {
    logic [StoreAddrW-1:0] addr;
    logic [StoreDataW-1:0] data;
  } entry_t;

endpackage

// File: rtl/store_word_buffer_if.sv
// Store channel from the MEM stage and drain channel to the byte-serializing RAM writer.
interface store_word_buffer_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 32
) ();

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] ser_data_in;
  logic [ADDR_W-1:0] ser_address;
  logic              ser_write_enable;
  logic              ser_done;

  modport master (
    output st_valid, st_addr, st_data, ser_done,
    input  st_ready, ser_data_in, ser_address, ser_write_enable
  );

  modport slave (
    input  st_valid, st_addr, st_data, ser_done,
    output st_ready, ser_data_in, ser_address, ser_write_enable
  );

endinterface

// File: rtl/store_buf_fwd_cam.sv
// Load-to-store forwarding: exact-address compare over occupied entries, youngest match wins.
module store_buf_fwd_cam
  import store_buf_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = StoreAddrW,
  parameter int unsigned DATA_W = StoreDataW,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  entry_t            entries_i [DEPTH],
  input  logic [PtrW-1:0]   rd_ptr_i,
  input  logic [CntW-1:0]   count_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_i + PtrW'(i);
      if ((CntW'(i) < count_i) && (ADDR_W'(entries_i[idx].addr) == ld_addr_i)) begin
        hit_o  = 1'b1;
        data_o = DATA_W'(entries_i[idx].data);
      end
    end
  end

endmodule

// File: rtl/store_word_buffer.sv
// Store word buffer between the MEM stage and the byte-serializing RAM writer.
// Optional load forwarding is built when STORE_BUF_FWD_EN is defined.
module store_word_buffer
  import store_buf_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = StoreAddrW,
  parameter int unsigned DATA_W = StoreDataW,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic                clk,
  input  logic                rst,
  store_word_buffer_if.slave  bus,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                ld_hit,
  output logic [DATA_W-1:0]   ld_data,
  output logic                pending,
  output logic [CntW-1:0]     count
);

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  drain_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ser_addr_q, ser_addr_d;
  logic [DATA_W-1:0] ser_data_q, ser_data_d;
  logic              push, pop;

  assign bus.st_ready = (count_q != CntW'(DEPTH));
  assign push         = bus.st_valid && bus.st_ready;

  always_comb begin
    state_d    = state_q;
    ser_addr_d = ser_addr_q;
    ser_data_d = ser_data_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          ser_addr_d = ADDR_W'(mem_q[rd_ptr_q].addr);
          ser_data_d = DATA_W'(mem_q[rd_ptr_q].data);
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (bus.ser_done) state_d = StRelease;
      end
      StRelease: begin
        // Head leaves only now, so it stays visible to forwarding for the whole drain.
        pop     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      ser_addr_q <= '0;
      ser_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      ser_addr_q <= ser_addr_d;
      ser_data_q <= ser_data_d;
    end
  end

  // Storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: StoreAddrW'(bus.st_addr), data: StoreDataW'(bus.st_data)};
    end
  end

  // Enable drops in the done cycle so the writer does not restart at byte 0.
  assign bus.ser_write_enable = (state_q == StIssue) && !bus.ser_done && !rst;
  assign bus.ser_address      = ser_addr_q;
  assign bus.ser_data_in      = ser_data_q;
  assign pending              = (count_q != '0) || (state_q != StIdle);
  assign count                = count_q;

`ifdef STORE_BUF_FWD_EN
  store_buf_fwd_cam #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd_cam (
    .entries_i (mem_q),
    .rd_ptr_i  (rd_ptr_q),
    .count_i   (count_q),
    .ld_addr_i (ld_addr),
    .hit_o     (ld_hit),
    .data_o    (ld_data)
  );
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^ld_addr;
  assign ld_hit         = 1'b0;
  assign ld_data        = '0;
`endif

endmodule

// File: doc/store_word_buffer.md
# store_word_buffer

Buffers 32-bit stores from the pipelined CPU's MEM stage and drains them one at a time into the byte-serializing RAM writer. The writer takes 4 cycles per word and needs its enable held across the whole sequence. This block decouples the pipeline from that latency: a store costs the pipeline one handshake cycle unless the buffer is full. It sits between the MEM stage and the 32-bit-to-byte RAM writer.

## Interface
- DEPTH, 4: number of buffered stores; power of two, 2..16
- ADDR_W, 19: byte address width
- DATA_W, 32: store word width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  MEM stage presents a store
- st_ready  out  1  buffer can accept a store; equals !full
- st_addr  in  ADDR_W  store byte base address
- st_data  in  DATA_W  store data
- ser_data_in  out  DATA_W  word for the writer
- ser_address  out  ADDR_W  base address for the writer
- ser_write_enable  out  1  writer enable
- ser_done  in  1  writer completion flag
- ld_addr  in  ADDR_W  address of the load currently in MEM
- ld_hit  out  1  forwarding hit (see Configuration)
- ld_data  out  DATA_W  forwarded data
- pending  out  1  buffer not empty or drain in progress
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- The storage is a circular FIFO with wr_ptr and rd_ptr, each $clog2(DEPTH) bits wide and wrapping modulo DEPTH, plus a separate count register.
- **Push:** occurs when st_valid && st_ready.
- **Pop:** occurs in the drain state machine only.
- **Push and pop in the same cycle:** count is unchanged and both pointers advance.
- **Push when full:** blocked by st_ready=0, including in a cycle where a pop also happens. st_ready is derived from registered count only.
- The drain state machine has three states, defined in the package: IDLE, ISSUE, RELEASE.
  - IDLE: if count!=0, register the head entry into ser_address/ser_data_in, then go to ISSUE. Otherwise stay.
  - ISSUE: ser_write_enable=1. When ser_done=1, go to RELEASE.
  - RELEASE: ser_write_enable=0. Pop the head, then go to IDLE.
- ser_write_enable is decoded from the state. It is 1 only in ISSUE with ser_done=0, and it is forced to 0 while rst=1. Dropping the enable in the cycle where ser_done is seen stops the writer from restarting at byte 0.
- ser_address and ser_data_in hold their values from the IDLE latch until the next latch.
- The head entry stays in the FIFO until the RELEASE pop, so it remains visible to forwarding.
- pending = (count!=0) || (state!=IDLE).

## Timing
- **Reset values:**
  - st_ready=1, ser_write_enable=0, ser_address=0, ser_data_in=0
  - ld_hit=0, ld_data=0, pending=0, count=0
  - pointers=0, state=IDLE
- **Store acceptance:** a store accepted at edge N is countable at N+1. It can be latched for drain in the cycle after N+1 at the earliest.
- **Drain cadence, per word:**
  - 1 cycle in IDLE (latch)
  - 4 cycles in ISSUE with enable high (bytes 0..3)
  - 1 cycle in ISSUE with ser_done=1 and enable low
  - 1 cycle in RELEASE
  - This gives 7 cycles per word, with at least 2 enable-low cycles between words so the writer clears its done flag.
- ser_done=1 outside ISSUE is ignored.
- **Reset mid-drain:** the in-flight entry is discarded and the enable is low in the reset cycle. The writer has no reset, so system reset sequencing must hold the writer's enable low for at least 1 cycle. That is satisfied by the previous point.
- ld_hit and ld_data are combinational from ld_addr and the registered FIFO contents.

## Configuration
- STORE_BUF_FWD_EN defined:
  - Compare ld_addr for exact full-width equality against every occupied entry.
  - On a match, ld_hit=1 and ld_data = data of the youngest matching entry, i.e. closest to wr_ptr-1.
  - Partial overlaps, meaning a different base address within 3 bytes, are not detected. The MEM stage must stall on pending instead.
- STORE_BUF_FWD_EN undefined:
  - ld_hit=0 and ld_data=0 constantly. There is no comparator logic.
  - The hazard unit stalls loads while pending=1.

## Structure
- Package store_buf_pkg holds:
  - the state enum (IDLE, ISSUE, RELEASE)
  - the default localparams for ADDR_W and DATA_W
  - the entry struct {addr, data}
- Sub-module store_buf_fwd_cam holds the occupied-entry compare and the youngest-match priority select. It is instantiated only under STORE_BUF_FWD_EN.

## Test plan
- **Single store:** push addr=0x00100, data=0xDEADBEEF into an empty buffer, with a writer model raising done after 4 enable cycles. Required: enable high exactly 4 cycles, then enable low in the done cycle; one pop; count returns to 0; pending falls 7 cycles after latch.
- **Fill to full:** push 4 stores back-to-back with the writer stalled. Required: st_ready=0 after the 4th push; a 5th st_valid is not accepted; stores drain in FIFO order with addresses 0x0, 0x4, 0x8, 0xC.
- **Push and pop in the same cycle at count=2:** required: count stays 2; after 2 laps of the pointers, data order is preserved.
- **Forwarding (with STORE_BUF_FWD_EN):** stores 0x40←0x11111111, then 0x40←0x22222222, then 0x44←0x33. With ld_addr=0x40, required: ld_hit=1 and ld_data=0x22222222. With ld_addr=0x41, required: ld_hit=0.
- **Reset mid-drain:** assert rst during the 2nd enable cycle of a word, with 3 entries queued. Required: enable=0 in the reset cycle; the next cycle shows count=0 and pending=0; no further enable pulses.
- **Stray ser_done:** ser_done=1 while in IDLE with an empty buffer. Required: no state change and no pop.
